// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and constants for the bit-serial subtractor.
//   state_e    - controller states (idle / shifting / done pulse)
//   DefaultWidth - default operand width
//   cnt_width()  - bit counter width for a given operand width
package serial_sub_pkg;

  localparam int unsigned DefaultWidth = 8;

  // Counter must be able to hold values 0..width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/serial_sub_fs_bit.sv
// fs_bit: combinational one-bit full subtractor, computes a - b - c.
// Ports:
//   a, b, c - minuend bit, subtrahend bit, borrow in
//   diff    - difference bit
//   borrow  - borrow out
module fs_bit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b ^ c;
  assign borrow = (~a & b) | (~a & c) | (b & c);

endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial unsigned subtractor, diff = (a - b - bin) mod 2^WIDTH, LSB first,
// one bit per clock through a single fs_bit cell.
// Optional feature macro: SERIAL_SUB_BORROW_IN_EN adds the borrow_in port (bin = borrow_in);
// otherwise bin = 0.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   start           - request, sampled only in idle
//   a, b            - operands, sampled on the accepting edge
//   borrow_in       - (optional) borrow into the LSB, sampled with a/b
//   busy            - high while bits are being processed
//   done            - one-cycle pulse when diff/borrow_out become valid
//   diff            - result register (shows partial values while busy)
//   borrow_out      - final borrow, i.e. a < b + bin
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BORROW_IN_EN
  input  logic             borrow_in,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e          state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic            br;
  logic [CntW-1:0] cnt;
  logic            bin;
  logic            cell_diff;
  logic            cell_borrow;

`ifdef SERIAL_SUB_BORROW_IN_EN
  assign bin = borrow_in;
`else
  assign bin = 1'b0;
`endif

  fs_bit u_fs_bit (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c     (br),
    .diff  (cell_diff),
    .borrow(cell_borrow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      a_sh       <= '0;
      b_sh       <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= StShift;
          end
        end
        StShift: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= cell_borrow;
          // Result enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          diff <= {cell_diff, diff[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == CntW'(WIDTH - 1)) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            borrow_out <= cell_borrow;
            state      <= StDone;
          end
        end
        StDone: begin
          done  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
